// File: rtl/lsu_mem_access.sv
// Memory-access stage: runs one load/store over a valid/ready data bus and
// returns aligned, sign/zero-extended load data to writeback.
module lsu_mem_access #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned BUS_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_addr,
  input  logic [XLEN-1:0]      in_store_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [BUS_BYTES-1:0] mem_req_wmask,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_load,
  output logic [XLEN-1:0]      out_mem_data,
  output logic                 out_misalign
);

  localparam int unsigned OFF_W = $clog2(BUS_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q,        state_d;
  logic [2:0]           funct3_q,       funct3_d;
  logic [OFF_W-1:0]     off_q,          off_d;
  logic                 req_we_q,       req_we_d;
  logic [XLEN-1:0]      req_addr_q,     req_addr_d;
  logic [XLEN-1:0]      req_wdata_q,    req_wdata_d;
  logic [BUS_BYTES-1:0] req_wmask_q,    req_wmask_d;
  logic                 out_is_load_q,  out_is_load_d;
  logic                 out_misalign_q, out_misalign_d;
  logic [XLEN-1:0]      out_mem_data_q, out_mem_data_d;

  logic                 illegal;
  logic                 misaligned;
  logic [BUS_BYTES-1:0] base_mask;
  logic [XLEN-1:0]      shifted;
  logic [XLEN-1:0]      load_val;

  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_is_load   = out_is_load_q;
  assign out_misalign  = out_misalign_q;
  assign out_mem_data  = out_mem_data_q;

  // Incoming op legality, natural alignment and store byte-enable pattern
  always_comb begin
    illegal    = in_is_load ? (in_funct3 == 3'b111) : in_funct3[2];
    misaligned = 1'b0;
    base_mask  = '0;
    case (in_funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        base_mask  = BUS_BYTES'(8'h01);
      end
      2'b01: begin
        misaligned = in_addr[0];
        base_mask  = BUS_BYTES'(8'h03);
      end
      2'b10: begin
        misaligned = |in_addr[1:0];
        base_mask  = BUS_BYTES'(8'h0F);
      end
      default: begin
        misaligned = |in_addr[2:0];
        base_mask  = BUS_BYTES'(8'hFF);
      end
    endcase
  end

  // Response lane extraction and extension
  always_comb begin
    shifted = mem_resp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      3'b110:  load_val = XLEN'(shifted[31:0]);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_wmask_d    = req_wmask_q;
    out_is_load_d  = out_is_load_q;
    out_misalign_d = out_misalign_q;
    out_mem_data_d = out_mem_data_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          funct3_d       = in_funct3;
          off_d          = in_addr[OFF_W-1:0];
          req_we_d       = !in_is_load;
          req_addr_d     = {in_addr[XLEN-1:OFF_W], OFF_W'(0)};
          req_wdata_d    = in_is_load ? '0 : (in_store_data << {in_addr[OFF_W-1:0], 3'b000});
          req_wmask_d    = in_is_load ? '0 : (base_mask << in_addr[OFF_W-1:0]);
          out_is_load_d  = 1'b0;
          out_mem_data_d = '0;
          out_misalign_d = illegal || misaligned;
          state_d        = (illegal || misaligned) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          out_is_load_d  = !req_we_q;
          out_mem_data_d = req_we_q ? '0 : load_val;
          state_d        = S_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      funct3_q       <= '0;
      off_q          <= '0;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wmask_q    <= '0;
      out_is_load_q  <= 1'b0;
      out_misalign_q <= 1'b0;
      out_mem_data_q <= '0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_wmask_q    <= req_wmask_d;
      out_is_load_q  <= out_is_load_d;
      out_misalign_q <= out_misalign_d;
      out_mem_data_q <= out_mem_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: driver, bus responder and result
// monitor run as independent processes against a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_is_load, out_misalign;
  logic [63:0] out_mem_data;

  lsu_mem_access #(.XLEN(64), .BUS_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_load(out_is_load),
    .out_mem_data(out_mem_data), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } req_t;

  typedef struct {
    logic        is_load;
    logic        misalign;
    logic [63:0] data;
  } out_t;

  req_t exp_req[$];
  out_t exp_out[$];
  int   checks = 0;
  int   errors = 0;
  int   req_mode = 0;   // 0 random ready, 1 ready held low
  int   out_mode = 0;   // 0 random, 1 held low, 2 held high
  bit   hold_resp = 1'b0;
  bit   pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Reference model written from byte lanes rather than shifters
  function automatic void model(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] sd, input logic [63:0] rdata,
                                output bit ok, output req_t r, output out_t o);
    int size = 1 << f3[1:0];
    int off  = int'(addr[2:0]);
    logic [63:0] val = '0;
    ok = ld ? (f3 != 3'd7) : (f3 < 3'd4);
    ok = ok && ((off % size) == 0);
    r.we    = !ld;
    r.addr  = addr - 64'(off);
    r.rdata = rdata;
    r.wdata = sd << (8 * off);
    r.wmask = '0;
    if (!ld) for (int i = 0; i < size; i++) r.wmask[off + i] = 1'b1;
    for (int i = 0; i < size; i++) val[8*i +: 8] = rdata[8*(off + i) +: 8];
    if (!f3[2] && size < 8 && val[8*size - 1])
      for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
    o.is_load  = ok && ld;
    o.misalign = !ok;
    o.data     = (ok && ld) ? val : 64'd0;
  endfunction

  // Called half a step after posedge; returns half a step after the accepting posedge
  task automatic send(input logic ld, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] sd, input logic [63:0] rdata, output int waited);
    bit   ok;
    req_t r;
    out_t o;
    model(ld, f3, addr, sd, rdata, ok, r, o);
    in_is_load = ld; in_funct3 = f3; in_addr = addr; in_store_data = sd; in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      if (waited > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=no_accept expected=accept");
        in_valid = 1'b0;
        return;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (ok) exp_req.push_back(r);
    exp_out.push_back(o);
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = $urandom_range(0, 1); in_funct3 = 3'($urandom);
    in_addr = r64(); in_store_data = r64();
    if (!ok) begin
      @(negedge clk);
      chk("misalign_latency", 64'({out_valid, out_misalign, mem_req_valid}), 64'(3'b110));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_out.size() != 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    if (exp_out.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_out.size());
    end
    #1;
  endtask

  // Bus responder: checks every presented request against the scoreboard
  initial begin
    req_t r;
    int   cnt = 0;
    logic [63:0] pend_rdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0 && !hold_resp) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = pend_rdata; pend = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
        end
      end else if (mem_req_valid) begin
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_rdata = r64();
      end
      mem_req_ready = (req_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (!rst && mem_req_valid) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected actual=valid expected=no_request addr=%h", mem_req_addr);
        end else begin
          r = exp_req[0];
          chk("req_we", 64'(mem_req_we), 64'(r.we));
          chk("req_addr", mem_req_addr, r.addr);
          chk("req_wmask", 64'(mem_req_wmask), 64'(r.wmask));
          if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
          if (mem_req_ready) begin
            void'(exp_req.pop_front());
            pend = 1'b1;
            cnt = $urandom_range(0, 2);
            pend_rdata = r.rdata;
          end
        end
      end
    end
  end

  // Result monitor: pops expectations on each out handshake, checks stall stability
  initial begin
    out_t e;
    bit   stalled = 1'b0;
    out_t prev;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = (out_mode == 1) ? 1'b0 : (out_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_mem_data, prev.data);
          chk("stall_flags", 64'({out_is_load, out_misalign}), 64'({prev.is_load, prev.misalign}));
        end
        stalled = 1'b0;
        if (out_valid) begin
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) begin
            if (exp_out.size() == 0) begin
              checks++; errors++;
              $display("FAIL out_unexpected actual=valid expected=idle");
            end else begin
              e = exp_out.pop_front();
              chk("out_is_load", 64'(out_is_load), 64'(e.is_load));
              chk("out_misalign", 64'(out_misalign), 64'(e.misalign));
              chk("out_mem_data", out_mem_data, e.data);
            end
          end else begin
            stalled = 1'b1;
            prev.data = out_mem_data; prev.is_load = out_is_load; prev.misalign = out_misalign;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, 64'({mem_req_valid, mem_req_we, out_valid, out_is_load, out_misalign, in_ready}), 64'd0);
    chk({tag, "_wmask"}, 64'(mem_req_wmask), 64'd0);
    chk({tag, "_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_wdata"}, mem_req_wdata, 64'd0);
    chk({tag, "_data"}, out_mem_data, 64'd0);
  endtask

  localparam logic [63:0] RD = 64'h1122_3344_8566_7788;

  initial begin
    int w;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_funct3 = '0;
    in_addr = '0; in_store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send(1'b1, 3'b000, 64'h8000_0003, r64(), RD, w);                 // LB
    send(1'b1, 3'b101, 64'h8000_0006, r64(), RD, w);                 // LHU
    send(1'b1, 3'b010, 64'h8000_0004, r64(), RD, w);                 // LW
    drain();

    req_mode = 1;
    send(1'b0, 3'b001, 64'h8000_000A, 64'h0000_0000_0000_ABCD, r64(), w);  // SH held
    repeat (3) @(posedge clk);
    req_mode = 0;
    #1;
    send(1'b1, 3'b010, 64'h8000_0002, r64(), r64(), w);              // misaligned LW
    send(1'b1, 3'b111, 64'h8000_0000, r64(), r64(), w);              // illegal load
    drain();

    out_mode = 1;
    send(1'b1, 3'b011, 64'h8000_0010, r64(), r64(), w);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    @(posedge clk);
    out_mode = 2;
    #1;
    send(1'b0, 3'b011, 64'h8000_0018, r64(), r64(), w);
    chk("accept_after_out", 64'(w), 64'd1);
    out_mode = 0;
    drain();

    hold_resp = 1'b1;
    send(1'b1, 3'b011, 64'h8000_0020, r64(), r64(), w);
    n = 0;
    while (!pend && n < 100) begin @(posedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midresp");
    exp_out.delete();
    exp_req.delete();
    hold_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      logic [63:0] a = r64();
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      send(1'($urandom_range(0, 1)), 3'($urandom), a, r64(), r64(), w);
    end
    drain();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
